// File: rtl/arb_pkg.sv
// Shared types and helpers for the cache-line memory arbiters.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int MAX_ADDR_W = 64;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int line_w);
    int off_bits;
    off_bits = $clog2(line_w / 8);
    return addr & ~((MAX_ADDR_W'(1) << off_bits) - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection: lowest set index (fixed) or the first set index
// after the round-robin pointer, wrapping modulo NUM_PORTS.
module arb_select
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [$clog2(NUM_PORTS)-1:0] i_rr_ptr,
  input  arb_mode_t                    i_mode,
  output logic [$clog2(NUM_PORTS)-1:0] o_winner,
  output logic                         o_valid
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  assign o_valid = |i_req;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    if (i_mode == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (i_req[i]) o_winner = IDX_W'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_PORTS);
        if (!w_found && i_req[w_idx]) begin
          o_winner = w_idx;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// N-client cache-line arbiter: serialises client line reads/writes onto one burst-memory
// port and returns a one-cycle completion pulse to the granted client.
module line_mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int ARB_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         cl_read,
  input  logic [NUM_PORTS-1:0]         cl_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]  cl_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]  cl_wdata,
  output logic [NUM_PORTS-1:0]         cl_resp,
  output logic [LINE_W-1:0]            cl_rdata,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [ADDR_W-1:0]            pmem_addr,
  output logic [LINE_W-1:0]            pmem_wdata,
  input  logic [LINE_W-1:0]            pmem_rdata,
  input  logic                         pmem_resp,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         proto_err
);
  localparam int        IDX_W = $clog2(NUM_PORTS);
  localparam arb_mode_t MODE  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_winner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_op_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [LINE_W-1:0]  r_wdata;
  logic [LINE_W-1:0]  r_rdata;
  logic               r_proto_err;

  logic [NUM_PORTS-1:0] w_req;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_valid;
  logic                 w_grant;

  assign w_req   = cl_read | cl_write;
  assign w_grant = (r_state == IDLE) && w_valid;

  arb_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_select (
    .i_req   (w_req),
    .i_rr_ptr(r_rr_ptr),
    .i_mode  (MODE),
    .o_winner(w_winner),
    .o_valid (w_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    cl_resp     = '0;
    unique case (r_state)
      IDLE: if (w_valid) w_state_nxt = BUSY;
      BUSY: begin
        pmem_read  = ~r_op_write;
        pmem_write = r_op_write;
        if (pmem_resp) w_state_nxt = DONE;
      end
      DONE: begin
        cl_resp[r_winner] = 1'b1;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide line registers are reset too because they drive outputs that must
      // read zero out of reset; they are plain flops, not a memory array.
      r_state     <= IDLE;
      r_winner    <= '0;
      r_rr_ptr    <= IDX_W'(NUM_PORTS - 1);
      r_op_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (|(cl_read & cl_write)) r_proto_err <= 1'b1;
      if (w_grant) begin
        r_winner   <= w_winner;
        r_rr_ptr   <= w_winner;
        r_op_write <= cl_write[w_winner];
        r_addr     <= ADDR_W'(line_align(MAX_ADDR_W'(cl_addr[w_winner*ADDR_W +: ADDR_W]), LINE_W));
        r_wdata    <= cl_wdata[w_winner*LINE_W +: LINE_W];
      end
      // Read data is captured on the completion beat; for writes it is simply unused.
      if ((r_state == BUSY) && pmem_resp) r_rdata <= pmem_rdata;
    end
  end

  assign cl_rdata   = r_rdata;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;
  assign grant_id   = r_winner;
  assign busy       = (r_state != IDLE);
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: one fixed-priority and one round-robin instance, each with
// a behavioural line memory and a client-level model of which request must win.
module tb_line_mem_arbiter;
  localparam int NP = 4;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int ND = 2;    // instance 0: fixed priority, instance 1: round-robin
  localparam int CW = 320;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NP-1:0]    cl_read    [ND];
  logic [NP-1:0]    cl_write   [ND];
  logic [NP*AW-1:0] cl_addr    [ND];
  logic [NP*LW-1:0] cl_wdata   [ND];
  logic [NP-1:0]    cl_resp    [ND];
  logic [LW-1:0]    cl_rdata   [ND];
  logic             pmem_read  [ND];
  logic             pmem_write [ND];
  logic [AW-1:0]    pmem_addr  [ND];
  logic [LW-1:0]    pmem_wdata [ND];
  logic [LW-1:0]    pmem_rdata [ND];
  logic             pmem_resp  [ND];
  logic [1:0]       grant_id   [ND];
  logic             busy       [ND];
  logic             proto_err  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    line_mem_arbiter #(
      .NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .ARB_MODE(g)
    ) u_dut (
      .clk(clk), .reset(reset),
      .cl_read(cl_read[g]), .cl_write(cl_write[g]), .cl_addr(cl_addr[g]),
      .cl_wdata(cl_wdata[g]), .cl_resp(cl_resp[g]), .cl_rdata(cl_rdata[g]),
      .pmem_read(pmem_read[g]), .pmem_write(pmem_write[g]), .pmem_addr(pmem_addr[g]),
      .pmem_wdata(pmem_wdata[g]), .pmem_rdata(pmem_rdata[g]), .pmem_resp(pmem_resp[g]),
      .grant_id(grant_id[g]), .busy(busy[g]), .proto_err(proto_err[g])
    );
  end

  // Client model: what each client is currently asking for.
  bit            pend   [ND][NP];
  bit            p_rd   [ND][NP];
  bit            p_wr   [ND][NP];
  logic [AW-1:0] p_addr [ND][NP];
  logic [LW-1:0] p_wdata[ND][NP];
  int            last   [ND];
  bit            exp_perr[ND];
  int            gcount [ND][NP];

  // Memory model state.
  logic [LW-1:0] mem [logic [AW:0]];
  int            mem_lat   [ND];
  int            cnt       [ND];
  int            resp_cyc  [ND];
  logic [AW-1:0] seen_addr [ND];
  logic          seen_wr   [ND];
  logic [LW-1:0] seen_wdata[ND];

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_get(input int d, input logic [AW-1:0] a);
    logic [AW:0] k;
    k = {d[0], a};
    if (mem.exists(k)) return mem[k];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return (AW'($urandom_range(0, 63)) << 5) | AW'($urandom_range(0, 31));
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Expected winner from the pending set: lowest index, or first after the last grant.
  function automatic int pick(input int d);
    if (d == 0) begin
      for (int p = 0; p < NP; p++) if (pend[d][p]) return p;
    end else begin
      for (int k = 1; k <= NP; k++) if (pend[d][(last[d] + k) % NP]) return (last[d] + k) % NP;
    end
    return -1;
  endfunction

  function automatic bit any_pend(input int d);
    for (int p = 0; p < NP; p++) if (pend[d][p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int d);
    logic [NP-1:0]    r;
    logic [NP-1:0]    w;
    logic [NP*AW-1:0] a;
    logic [NP*LW-1:0] wd;
    r = '0; w = '0; a = '0; wd = '0;
    for (int p = 0; p < NP; p++) begin
      if (pend[d][p]) begin
        r[p] = p_rd[d][p];
        w[p] = p_wr[d][p];
        a[p*AW +: AW]  = p_addr[d][p];
        wd[p*LW +: LW] = p_wdata[d][p];
      end
    end
    cl_read[d] = r; cl_write[d] = w; cl_addr[d] = a; cl_wdata[d] = wd;
  endtask

  task automatic raise(input int d, input int p, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] wd);
    pend[d][p] = 1'b1; p_rd[d][p] = rd; p_wr[d][p] = wr;
    p_addr[d][p] = a; p_wdata[d][p] = wd;
    if (rd && wr) exp_perr[d] = 1'b1;
    drive(d);
  endtask

  task automatic raise_rand(input int d, input int p);
    bit wr;
    wr = 1'($urandom_range(0, 1));
    raise(d, p, !wr, wr, rand_addr(), rand_line());
  endtask

  // Waits for the next completion and checks it against the model; returns the observed port.
  task automatic serve_one(input int d, output int won);
    int            exp_p;
    bit            seen;
    logic [NP-1:0] oh;
    logic [AW-1:0] ea;
    won   = -1;
    exp_p = pick(d);
    if (exp_p < 0) return;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("resp_gap", CW'(cl_resp[d]), CW'(0));
      else if (cl_resp[d] != '0) seen = 1'b1;
    end
    check("resp_seen", CW'(seen), CW'(1));
    for (int p = NP - 1; p >= 0; p--) if (cl_resp[d][p]) won = p;
    if (seen) begin
      oh = NP'(1) << exp_p;
      ea = p_addr[d][exp_p] & ~32'h1F;
      check("resp_onehot", CW'(cl_resp[d]), CW'(oh));
      check("grant_id", CW'(grant_id[d]), CW'(exp_p));
      check("resp_latency", CW'(cyc), CW'(resp_cyc[d] + 1));
      check("pmem_drop", CW'({pmem_read[d], pmem_write[d]}), CW'(0));
      check("busy_done", CW'(busy[d]), CW'(1));
      check("pmem_op", CW'(seen_wr[d]), CW'(p_wr[d][exp_p]));
      check("pmem_addr", CW'(seen_addr[d]), CW'(ea));
      if (p_wr[d][exp_p]) check("pmem_wdata", CW'(seen_wdata[d]), CW'(p_wdata[d][exp_p]));
      else check("cl_rdata", CW'(cl_rdata[d]), CW'(mem_get(d, ea)));
      check("proto_err", CW'(proto_err[d]), CW'(exp_perr[d]));
      if (won >= 0) gcount[d][won]++;
    end
    pend[d][exp_p] = 1'b0;
    last[d] = exp_p;
    drive(d);
  endtask

  task automatic drain(input int d);
    int won;
    while (any_pend(d)) serve_one(d, won);
  endtask

  // Reset is asserted while clients drop everything; outputs must be zero one cycle later.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP; p++) pend[d][p] = 1'b0;
      drive(d);
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_pmem", CW'({pmem_read[d], pmem_write[d]}), CW'(0));
      check("rst_busy", CW'(busy[d]), CW'(0));
      check("rst_resp", CW'(cl_resp[d]), CW'(0));
      check("rst_perr", CW'(proto_err[d]), CW'(0));
      check("rst_gid", CW'(grant_id[d]), CW'(0));
      check("rst_addr", CW'(pmem_addr[d]), CW'(0));
      last[d] = NP - 1;
      exp_perr[d] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Burst-memory responder: answers after mem_lat request cycles and checks the request holds.
  initial begin
    for (int d = 0; d < ND; d++) begin
      pmem_resp[d] = 1'b0; pmem_rdata[d] = '0; cnt[d] = 0; resp_cyc[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (reset || pmem_resp[d]) begin
          pmem_resp[d] = 1'b0;
          cnt[d] = 0;
        end else if (pmem_read[d] || pmem_write[d]) begin
          if (cnt[d] == 0) begin
            seen_addr[d] = pmem_addr[d]; seen_wr[d] = pmem_write[d]; seen_wdata[d] = pmem_wdata[d];
          end else begin
            check("pmem_hold", CW'({pmem_write[d], pmem_addr[d], pmem_wdata[d]}),
                  CW'({seen_wr[d], seen_addr[d], seen_wdata[d]}));
          end
          cnt[d]++;
          if (cnt[d] >= mem_lat[d]) begin
            pmem_resp[d] = 1'b1;
            resp_cyc[d]  = cyc;
            if (pmem_write[d]) mem[{d[0], pmem_addr[d]}] = pmem_wdata[d];
            else pmem_rdata[d] = mem_get(d, pmem_addr[d]);
          end
        end
      end
    end
  end

  initial begin
    int            won;
    int            mx;
    int            mn;
    logic [LW-1:0] line;
    for (int d = 0; d < ND; d++) begin
      cl_read[d] = '0; cl_write[d] = '0; cl_addr[d] = '0; cl_wdata[d] = '0;
      mem_lat[d] = 2; last[d] = NP - 1; exp_perr[d] = 1'b0;
      for (int p = 0; p < NP; p++) gcount[d][p] = 0;
    end
    do_reset();

    // Single read, 4-cycle memory latency.
    mem[{1'b0, 32'h0000_0040}] = {32{8'hA5}};
    mem_lat[0] = 4;
    raise(0, 1, 1'b1, 1'b0, 32'h0000_0040, '0);
    @(negedge clk);
    check("req_visible", CW'(pmem_read[0]), CW'(1));
    check("req_addr", CW'(pmem_addr[0]), CW'(32'h0000_0040));
    serve_one(0, won);
    check("single_port", CW'(won), CW'(1));
    check("single_rdata", CW'(cl_rdata[0]), CW'({32{8'hA5}}));

    // Write path, then read the line back from another port through a misaligned address.
    line = {8{32'hDEAD_BEEF}};
    mem_lat[0] = 3;
    raise(0, 0, 1'b0, 1'b1, 32'h0000_2000, line);
    serve_one(0, won);
    check("write_port", CW'(won), CW'(0));
    raise(0, 2, 1'b1, 1'b0, 32'h0000_2010, '0);
    serve_one(0, won);
    check("readback", CW'(cl_rdata[0]), CW'(line));

    // Fixed priority: port 0 keeps re-requesting against a waiting port 3.
    raise(0, 0, 1'b1, 1'b0, 32'h0000_0100, '0);
    raise(0, 3, 1'b1, 1'b0, 32'h0000_0300, '0);
    for (int i = 0; i < 3; i++) begin
      serve_one(0, won);
      check("fixed_win", CW'(won), CW'(0));
      if (i < 2) raise(0, 0, 1'b1, 1'b0, AW'(32'h100 + (i + 1) * 32), '0);
    end
    serve_one(0, won);
    check("fixed_late", CW'(won), CW'(3));

    // Reset in the middle of a long memory access.
    mem_lat[0] = 20;
    raise(0, 0, 1'b1, 1'b0, 32'h0000_3000, '0);
    repeat (3) @(negedge clk);
    check("busy_before_rst", CW'(busy[0]), CW'(1));
    do_reset();
    mem_lat[0] = 3;
    raise(0, 0, 1'b1, 1'b0, 32'h0000_1004, '0);
    @(negedge clk);
    check("post_rst_addr", CW'(pmem_addr[0]), CW'(32'h0000_1000));
    serve_one(0, won);

    // Round-robin with every client requesting continuously.
    mem_lat[1] = 2;
    for (int p = 0; p < NP; p++) begin
      gcount[1][p] = 0;
      raise(1, p, 1'b1, 1'b0, rand_addr(), '0);
    end
    for (int i = 0; i < 12; i++) begin
      serve_one(1, won);
      if (i < 6) check("rr_order", CW'(won), CW'(i % NP));
      if (won >= 0) raise(1, won, 1'b1, 1'b0, rand_addr(), '0);
    end
    mx = gcount[1][0]; mn = gcount[1][0];
    for (int p = 1; p < NP; p++) begin
      if (gcount[1][p] > mx) mx = gcount[1][p];
      if (gcount[1][p] < mn) mn = gcount[1][p];
    end
    check("rr_fair", CW'(mx - mn <= 1), CW'(1));
    check("rr_total", CW'(mx + mn), CW'(6));
    drain(1);

    // Read and write together: issued as a write, sticky error flag.
    raise(0, 1, 1'b1, 1'b1, 32'h0000_4000, line ^ {LW{1'b1}});
    serve_one(0, won);
    check("perr_set", CW'(proto_err[0]), CW'(1));
    raise(0, 2, 1'b1, 1'b0, 32'h0000_4000, '0);
    serve_one(0, won);
    check("perr_readback", CW'(cl_rdata[0]), CW'(line ^ {LW{1'b1}}));
    check("perr_sticky", CW'(proto_err[0]), CW'(1));

    // Random traffic on both instances.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 30; n++) begin
        if (!any_pend(d)) raise_rand(d, int'($urandom_range(0, NP - 1)));
        mem_lat[d] = int'($urandom_range(1, 5));
        serve_one(d, won);
        for (int p = 0; p < NP; p++) begin
          if (!pend[d][p] && $urandom_range(0, 3) == 0) raise_rand(d, p);
        end
      end
      drain(d);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Parametrised N-client arbiter that merges cache-line requests onto one burst-memory line port. It sits between the L1 caches and the cacheline adaptor.
- Generalises the fixed two-port instruction/data split of the mp4 top level to NUM_PORTS clients.
- Provides a selectable fixed-priority or round-robin mode, registered responses, and a protocol-error flag.

Parameters:
- NUM_PORTS, 2, number of client ports (2..8); port 0 is the dcache by convention.
- LINE_W, 256, cache-line width in bits.
- ADDR_W, 32, byte address width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cl_read  in  NUM_PORTS  per-client line read request
- cl_write  in  NUM_PORTS  per-client line write request
- cl_addr  in  NUM_PORTS*ADDR_W  per-client address; slice i is client i
- cl_wdata  in  NUM_PORTS*LINE_W  per-client write line
- cl_resp  out  NUM_PORTS  one-cycle completion pulse, one-hot
- cl_rdata  out  LINE_W  read line, shared by all clients; valid only with cl_resp
- pmem_read  out  1  downstream read request
- pmem_write  out  1  downstream write request
- pmem_addr  out  ADDR_W  downstream address, line-aligned
- pmem_wdata  out  LINE_W  downstream write line
- pmem_rdata  in  LINE_W  downstream read line
- pmem_resp  in  1  downstream completion
- grant_id  out  $clog2(NUM_PORTS)  index of the current or last granted client
- busy  out  1  high whenever state is not IDLE
- proto_err  out  1  sticky flag; set when any client asserts read and write together

Behaviour:
- Reset (synchronous, active-high): all outputs are 0, state is IDLE, rr_ptr = NUM_PORTS-1 (so port 0 is searched first), proto_err cleared. Reset mid-transaction drops pmem_read/pmem_write on the next edge. No cl_resp is issued for the aborted request.
- Request vector: req[i] = cl_read[i] | cl_write[i].
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If req is nonzero, select the winner, latch op/addr/wdata/winner, go to BUSY. Otherwise stay.
  - Fixed mode: the winner is the lowest set index.
  - RR mode: the winner is the first set index searched from rr_ptr+1 modulo NUM_PORTS. On grant, rr_ptr <= winner.
- Op encoding: write if cl_write[winner], else read. If both read and write are high, write wins and proto_err is set.
- Latched address: cl_addr slice with the low $clog2(LINE_W/8) bits forced to 0.
- BUSY:
  - pmem_read/pmem_write are driven from the latched op. pmem_addr and pmem_wdata come from the latches and are stable for the whole state.
  - When pmem_resp is sampled high, capture pmem_rdata into the rdata register, deassert pmem_* on the next edge, and go to DONE.
- DONE: exactly one cycle. cl_resp[winner] = 1, cl_rdata = captured line (write op: the captured value is don't-care). Then go to IDLE.
- Clients hold their request and signals until they see cl_resp, then drop them the following cycle. The arbiter never re-samples a client during BUSY or DONE.
- Latency:
  - Request first seen in IDLE at cycle 0 → pmem request visible in cycle 1.
  - pmem_resp in cycle k → cl_resp in cycle k+1 → IDLE in cycle k+2.
  - Back-to-back requests from the same or another client are granted no earlier than cycle k+2.
- Simultaneous requests: exactly one grant per transaction. The losers remain pending and are served in later IDLE cycles. In RR mode no client waits more than NUM_PORTS-1 transactions.
- A request that drops while pending (protocol violation) is simply not granted. No error is raised.
- grant_id holds its value after DONE until the next grant.

Decomposition:
- Shared package arb_pkg holds:
  - enum arb_state_t {IDLE, BUSY, DONE}
  - enum arb_mode_t {ARB_FIXED = 0, ARB_RR = 1}
  - function line_align(addr, LINE_W)
- One sub-module, arb_select: combinational winner selection from req, rr_ptr and mode. Outputs are winner index and valid. It is reused by future multi-bank arbiters.

Test Plan:
- Reset check: assert reset mid-BUSY → next cycle pmem_read = 0, busy = 0, no cl_resp. After release, a port-0 read at 0x0000_1004 issues pmem_addr = 0x0000_1000.
- Single read: port 1 reads 0x0000_0040; memory returns line 0xA5.. after 4 cycles → cl_resp[1] pulses exactly 1 cycle after pmem_resp, with cl_rdata = 0xA5.., and cl_resp[0] stays 0.
- Fixed priority: NUM_PORTS = 4, ports 0 and 3 request simultaneously, repeated 3 times, with port 0 re-requesting each time → port 0 is granted every time and port 3 is served only when port 0 is idle.
- Round-robin:
  - ARB_MODE = 1, NUM_PORTS = 4, all ports request continuously.
  - Required grant order after reset: 0, 1, 2, 3, 0, 1.
  - Per-port count check: no port has more than one grant above any other.
- Write path: port 0 writes 0xDEAD_BEEF.. to 0x0000_2000 → pmem_write = 1 with that wdata and address held constant until pmem_resp. After completion, cl_resp[0] = 1 for one cycle.
- Protocol error: port 1 asserts read and write together → a write is issued, proto_err rises and stays high until reset.
